rtc_frame_rx: RTL and testbench

- Receiving end of the framed RTC byte stream. Sits on the VGA side and rebuilds the 11 RTC register bytes into a stable parallel bank for display logic.
- The stream has a one-cycle active-low start marker on bit_inicio, then one guard cycle, then one byte slot per clock.
- Bytes are gathered into a shadow bank. The whole frame is committed to the outputs in one cycle, so the display never sees a half-updated time or date.

---
 rtl/rtc_frame_rx.sv | 167 ++++++++++++++++
 tb/tb_rtc_frame_rx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rtc_frame_rx.sv
// rtc_frame_rx: rebuilds the framed RTC byte stream into a register bank that is committed atomically.
// Optional feature macro: RTC_RX_BCD_CHECK_EN rejects frames that carry a non-BCD byte.

module rtc_rx_byte (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cap_i,
  input  logic       clr_i,
  input  logic       commit_i,
  input  logic       bypass_i,
  input  logic [7:0] d_i,
  output logic [7:0] q_o
);
  logic [7:0] shadow_q, out_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= 8'h00;
      out_q    <= 8'h00;
    end else begin
      if (clr_i)      shadow_q <= 8'h00;
      else if (cap_i) shadow_q <= d_i;
      // the last slot commits straight from the stream on its capture edge
      if (commit_i)   out_q    <= bypass_i ? d_i : shadow_q;
    end
  end

  assign q_o = out_q;
endmodule

module rtc_frame_rx #(
  parameter int                  NUM_REGS     = 11,
  parameter int                  GUARD_CYCLES = 1,
  parameter logic [NUM_REGS-1:0] SLOT_MASK    = 11'b11110111111
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  bit_inicio,
  input  logic [7:0]            data_in,
  input  logic                  hold,
  output logic [8*NUM_REGS-1:0] regs_out,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  in_frame
);
  localparam int SW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GUARD = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_REGS - 1);
  localparam logic [GW-1:0] GUARD_END = GW'(GUARD_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          prev_q, valid_q, err_q, in_frame_q;
  logic          marker, in_guard, in_capt, last, abort, bad_frame, commit, shadow_clr;

  assign marker   = prev_q & ~bit_inicio;
  assign in_guard = (state_q == S_GUARD);
  assign in_capt  = (state_q == S_CAPT);
  assign last     = in_capt && (slot_q == LAST_SLOT);
  // a marker on the last-slot edge lets that frame finish; anywhere else mid-frame it aborts
  assign abort    = marker && (in_guard || (in_capt && !last));

`ifdef RTC_RX_BCD_CHECK_EN
  logic bcd_bad_q, cur_bad;
  assign cur_bad   = in_capt && SLOT_MASK[slot_q] &&
                     ((data_in[7:4] > 4'd9) || (data_in[3:0] > 4'd9));
  assign bad_frame = bcd_bad_q | cur_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            bcd_bad_q <= 1'b0;
    else if (last || marker) bcd_bad_q <= 1'b0;
    else                     bcd_bad_q <= bad_frame;
  end
`else
  assign bad_frame = 1'b0;
`endif

  assign commit     = last && !hold && !bad_frame;
  assign shadow_clr = abort || last;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      S_IDLE: begin
        if (marker) begin
          state_d = S_GUARD;
          gcnt_d  = '0;
        end
      end
      S_GUARD: begin
        if (marker) begin
          gcnt_d = '0;
        end else if (gcnt_q == GUARD_END) begin
          state_d = S_CAPT;
          slot_d  = '0;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      S_CAPT: begin
        if (marker) begin
          state_d = S_GUARD;
          gcnt_d  = '0;
          slot_d  = '0;
        end else if (last) begin
          state_d = S_IDLE;
          slot_d  = '0;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        slot_d  = '0;
        gcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      gcnt_q     <= '0;
      prev_q     <= 1'b1;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      in_frame_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      gcnt_q     <= gcnt_d;
      prev_q     <= bit_inicio;
      valid_q    <= commit;
      err_q      <= abort || (last && !hold && bad_frame);
      in_frame_q <= (state_d == S_GUARD) || (state_d == S_CAPT);
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_byte
    if (SLOT_MASK[k]) begin : g_live
      rtc_rx_byte u_byte (
        .clk      (clk),
        .reset_n  (reset_n),
        .cap_i    (in_capt && (slot_q == SW'(k))),
        .clr_i    (shadow_clr),
        .commit_i (commit),
        .bypass_i ((k == NUM_REGS - 1) ? 1'b1 : 1'b0),
        .d_i      (data_in),
        .q_o      (regs_out[8*k +: 8])
      );
    end else begin : g_dead
      // never captured, so it holds its reset value forever
      assign regs_out[8*k +: 8] = 8'h00;
    end
  end

  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign in_frame    = in_frame_q;
endmodule

// File: tb/tb_rtc_frame_rx.sv
// tb_rtc_frame_rx: table-driven frames plus hand sequences, scoreboard of expected commit/error pulses.
module tb_rtc_frame_rx;
  localparam int N = 11;
  localparam logic [N-1:0] MASK = 11'b11110111111;
`ifdef RTC_RX_BCD_CHECK_EN
  localparam bit BCDP = 1'b1;
`else
  localparam bit BCDP = 1'b0;
`endif

  logic           clk = 1'b0, reset_n = 1'b0, bit_inicio = 1'b1, hold = 1'b0;
  logic [7:0]     data_in = 8'h00;
  logic [8*N-1:0] regs_out;
  logic           frame_valid, frame_err, in_frame;

  rtc_frame_rx dut (
    .clk(clk), .reset_n(reset_n), .bit_inicio(bit_inicio), .data_in(data_in), .hold(hold),
    .regs_out(regs_out), .frame_valid(frame_valid), .frame_err(frame_err), .in_frame(in_frame)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  typedef struct { int cyc; bit err; logic [8*N-1:0] regs; } evt_t;
  typedef struct { int gap; logic [8*N-1:0] bytes; logic hold; int kind; logic [8*N-1:0] exp_regs; } vec_t;

  evt_t sbq[$];
  vec_t tbl[6];
  int   n_cmp = 0, n_bad = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [8*N-1:0] act, input logic [8*N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd8(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // slot k carries base+k; slot 6 carries junk the receiver must ignore
  function automatic logic [8*N-1:0] pat(input int base, input bit bcd);
    logic [8*N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      r[8*k +: 8] = !MASK[k] ? 8'hEE : (bcd ? bcd8(base + k) : 8'(base + k));
    return r;
  endfunction

  function automatic logic [8*N-1:0] fr(input int hb);
    return BCDP ? pat((hb >> 4) * 10 + (hb & 15), 1'b1) : pat(hb, 1'b0);
  endfunction

  function automatic logic [8*N-1:0] masked(input logic [8*N-1:0] b);
    logic [8*N-1:0] r;
    r = b;
    for (int k = 0; k < N; k++) if (!MASK[k]) r[8*k +: 8] = 8'h00;
    return r;
  endfunction

  always @(negedge clk) begin
    evt_t e;
    if (mon_en && reset_n) begin
      if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        chk("missed_pulse_cyc", cyc, sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (frame_valid || frame_err) begin
        if (sbq.size() == 0) chk("unexpected_pulse", {frame_valid, frame_err}, 0);
        else begin
          e = sbq.pop_front();
          chk("pulse_cyc", cyc, e.cyc);
          chk("pulse_err", frame_err, e.err);
          chk("pulse_valid", frame_valid, !e.err);
          chk("pulse_regs", regs_out, e.regs);
        end
      end
    end
  end

  task automatic drive(input logic bi, input logic [7:0] d, input logic h);
    bit_inicio = bi; data_in = d; hold = h;
    @(negedge clk);
  endtask

  // kind: 0 no pulse, 1 commit, 2 error at the commit edge
  task automatic send_frame(input logic [8*N-1:0] b, input logic h, input int low_len,
                            input int kind, input logic [8*N-1:0] er);
    evt_t e;
    if (kind != 0) begin
      e.cyc = cyc + 13; e.err = (kind == 2); e.regs = er;
      sbq.push_back(e);
    end
    drive(1'b0, 8'h45, h);
    drive((low_len > 1) ? 1'b0 : 1'b1, 8'hC3, h);
    for (int k = 0; k < N; k++) drive((k + 2 < low_len) ? 1'b0 : 1'b1, b[8*k +: 8], h);
  endtask

  initial begin
    logic [8*N-1:0] bad, b, cur;
    evt_t e;
    bad = pat(20, 1'b1);
    bad[23:16] = 8'h5A;
    tbl[0] = '{9, fr('h01), 1'b0, 1, masked(fr('h01))};
    tbl[1] = '{0, fr('h20), 1'b0, 1, masked(fr('h20))};
    tbl[2] = '{2, fr('h40), 1'b1, 0, masked(fr('h20))};
    tbl[3] = '{0, fr('h30), 1'b0, 1, masked(fr('h30))};
`ifdef RTC_RX_BCD_CHECK_EN
    tbl[4] = '{3, bad, 1'b0, 2, masked(fr('h30))};
`else
    tbl[4] = '{3, bad, 1'b0, 1, masked(bad)};
`endif
    tbl[5] = '{0, pat(1, 1'b1), 1'b0, 1, masked(pat(1, 1'b1))};

    repeat (3) @(negedge clk);
    chk("rst_regs", regs_out, 0);
    chk("rst_valid", frame_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_in_frame", in_frame, 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < tbl[i].gap; g++) drive(1'b1, 8'h00, 1'b0);
      send_frame(tbl[i].bytes, tbl[i].hold, 1, tbl[i].kind, tbl[i].exp_regs);
      chk($sformatf("vec%0d_regs", i), regs_out, tbl[i].exp_regs);
      chk($sformatf("vec%0d_valid", i), frame_valid, (tbl[i].kind == 1));
      chk($sformatf("vec%0d_err", i), frame_err, (tbl[i].kind == 2));
    end
    cur = tbl[5].exp_regs;

    // second marker lands on slot 4: error there, restarted frame commits 12 later
    drive(1'b1, 8'h00, 1'b0);
    e.cyc = cyc + 7; e.err = 1'b1; e.regs = cur;
    sbq.push_back(e);
    drive(1'b0, 8'h45, 1'b0);
    drive(1'b1, 8'hC3, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b1, 8'h70 + 8'(k), 1'b0);
    chk("abort_in_frame", in_frame, 1);
    send_frame(pat(50, 1'b1), 1'b0, 1, 1, masked(pat(50, 1'b1)));
    chk("abort_new_regs", regs_out, masked(pat(50, 1'b1)));

    // marker held low three cycles: exactly one frame
    drive(1'b1, 8'h00, 1'b0);
    send_frame(pat(60, 1'b1), 1'b0, 3, 1, masked(pat(60, 1'b1)));
    repeat (4) drive(1'b1, 8'h00, 1'b0);
    chk("lowhold_regs", regs_out, masked(pat(60, 1'b1)));
    chk("lowhold_idle", in_frame, 0);

    // next marker on the last-slot edge: commit completes, no error, new frame follows
    b = pat(10, 1'b1);
    b[8*(N-1) +: 8] = 8'h45;
    e.cyc = cyc + 13; e.err = 1'b0; e.regs = masked(b);
    sbq.push_back(e);
    drive(1'b0, 8'h45, 1'b0);
    drive(1'b1, 8'hC3, 1'b0);
    for (int k = 0; k < N - 1; k++) drive(1'b1, b[8*k +: 8], 1'b0);
    send_frame(pat(70, 1'b1), 1'b0, 1, 1, masked(pat(70, 1'b1)));
    chk("overlap_regs", regs_out, masked(pat(70, 1'b1)));

    // async reset mid-frame loses the frame silently
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b0, 8'h45, 1'b0);
    drive(1'b1, 8'hC3, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, 8'h11, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_regs", regs_out, 0);
    chk("midrst_in_frame", in_frame, 0);
    chk("midrst_valid", frame_valid, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) drive(1'b1, 8'h00, 1'b0);
    send_frame(pat(30, 1'b1), 1'b0, 1, 1, masked(pat(30, 1'b1)));
    chk("postrst_regs", regs_out, masked(pat(30, 1'b1)));

    repeat (15) drive(1'b1, 8'h00, 1'b0);
    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
